strobe_cmp: RTL and testbench
=============================

# strobe_cmp

Per-pin compare/strobe unit for the ASIC tester: the receive-side counterpart of the force-format pin driver. It runs a test-cycle counter with the same cycle-length timing model as the driver and samples the synchronized DUT pin at a programmed strobe point or across a strobe window. Each sample is compared against a masked expected value, and the block reports a per-cycle pass/fail result plus accumulated fail statistics. One instance sits on each DUT output pin, alongside the pin's driver.

## Interface

Parameters:
- FCW, 16, width of fail counter and cycle index

Ports:
- CLK  in  1  tester clock; all logic on posedge
- RST_N  in  1  asynchronous, active-low reset
- EN  in  1  active-high enable for test-cycle counting and comparison
- CYCLE_LENGTH  in  10  CLK cycles per test cycle; legal 1..1023; 0 treated as 1
- STROBE_EDGE  in  10  counter value of the (first) strobe sample
- WINDOW_END  in  10  last counter value of the strobe window (MODE=1 only)
- MODE  in  1  0 = edge strobe (single sample), 1 = window strobe
- DUT_IN  in  1  DUT pin value, already synchronized upstream
- EXP  in  1  expected pin value for the current test cycle
- MASK  in  1  1 = don't-care; cycle always passes
- CLR_FAIL  in  1  synchronous clear of FAIL_COUNT, STICKY_FAIL, FIRST_FAIL_IDX
- CYCLE_DONE  out  1  one-CLK pulse; RESULT_FAIL is valid while it is high
- RESULT_FAIL  out  1  result of the just-completed test cycle
- STICKY_FAIL  out  1  set by any failing cycle; held until CLR_FAIL or reset
- FAIL_COUNT  out  FCW  number of failing cycles, saturating at all-ones
- FIRST_FAIL_IDX  out  FCW  cycle index of the first failure since clear
- CYCLE_IDX  out  FCW  number of completed test cycles since EN rose; wraps

## Operation

- Counter cnt:
  - Reset value 1.
  - While EN=1, increments each CLK. When cnt == effective CYCLE_LENGTH, the next value is 1.
  - While EN=0, held at 1.
- The counter value k is current during the k-th CLK of a test cycle.
- EXP, MASK and MODE are captured at cnt==1 and held for the whole test cycle. STROBE_EDGE, WINDOW_END and CYCLE_LENGTH must be static while EN=1.
- Per-cycle state is idle/armed/strobed/failed, held in two flags, `seen` and `mis`, both cleared at cnt==1.
  - Edge mode: at cnt==STROBE_EDGE, sample DUT_IN and set seen. Set mis if DUT_IN != EXP.
  - Window mode: at every cnt with STROBE_EDGE <= cnt <= WINDOW_END, set seen. Set mis on any DUT_IN != EXP. If WINDOW_END < STROBE_EDGE, the window is the single point at STROBE_EDGE.
- End of cycle (cnt == CYCLE_LENGTH, with the strobe evaluated that same clock):
  - fail = !MASK & (mis | !seen).
  - A strobe programmed beyond CYCLE_LENGTH therefore fails every unmasked cycle.
- Completion updates:
  - CYCLE_IDX increments.
  - On fail: STICKY_FAIL is set and FAIL_COUNT increments (saturating). FIRST_FAIL_IDX loads the pre-increment CYCLE_IDX if STICKY_FAIL was 0.
- EN falling mid-cycle: the partial cycle is discarded. No CYCLE_DONE pulse and no statistic update. cnt returns to 1 and the flags clear.
- EN rising: CYCLE_IDX clears to 0. FAIL statistics are not cleared.
- CLR_FAIL in the same clock as a failing completion: the clear is applied first, then the fail. Result: FAIL_COUNT=1, STICKY_FAIL=1, FIRST_FAIL_IDX = that cycle's index.
- RST_N low at any time: all state is cleared immediately, regardless of CLK.

## Timing

- Reset values: cnt=1; CYCLE_DONE=0, RESULT_FAIL=0, STICKY_FAIL=0, FAIL_COUNT=0, FIRST_FAIL_IDX=0, CYCLE_IDX=0.
- DUT_IN is sampled on the CLK edge that ends the clock in which cnt equals the strobe value.
- CYCLE_DONE, RESULT_FAIL and the statistics all update on the edge ending the cnt==CYCLE_LENGTH clock. CYCLE_DONE is high for exactly that following clock, so latency from the last strobe sample to the result is 1 CLK.
- With EN held high, CYCLE_DONE pulses once every CYCLE_LENGTH clocks. CYCLE_LENGTH=1 gives a pulse on every clock after the first.
- RESULT_FAIL holds its value between pulses.

## Test plan

- Edge pass/fail: CYCLE_LENGTH=10, STROBE_EDGE=5, MODE=0, EXP=1. DUT_IN=1 at cnt 5 -> CYCLE_DONE with RESULT_FAIL=0. Next cycle DUT_IN=0 at cnt 5 only -> RESULT_FAIL=1, FAIL_COUNT=1, FIRST_FAIL_IDX=1.
- Window glitch: MODE=1, STROBE_EDGE=3, WINDOW_END=7, EXP=0. A one-clock DUT_IN=1 at cnt 6 -> fail. The same glitch at cnt 8 -> pass.
- Mask and no-strobe: STROBE_EDGE=12, CYCLE_LENGTH=10 -> every cycle fails. Setting MASK=1 -> passes, and FAIL_COUNT stops incrementing.
- EN abort: drop EN at cnt 6 of a cycle containing a mismatch -> no CYCLE_DONE and FAIL_COUNT unchanged. Re-raise EN -> cnt restarts at 1 and CYCLE_IDX=0.
- Saturation/clear: FCW=4, force 20 failing cycles -> FAIL_COUNT=15. CLR_FAIL coincident with a failing completion -> FAIL_COUNT=1, STICKY_FAIL=1.
- Async reset: pulse RST_N low mid-cycle between CLK edges -> all outputs 0 immediately. Counting resumes from cnt=1 after release.

Source files
------------

// File: rtl/strobe_cmp.sv
// strobe_cmp: per-pin receive-side compare/strobe unit.
// Runs a test-cycle counter, samples the synchronized DUT pin at an edge strobe
// or across a strobe window, compares against a masked expected value and keeps
// per-cycle pass/fail plus accumulated fail statistics.
// Handshake: CYCLE_DONE is a one-clock valid pulse with no ready; RESULT_FAIL and
// CYCLE_IDX are valid while it is high, and no back-pressure is possible.
module strobe_cmp #(
   parameter int FCW = 16
) (
   input  logic           CLK,
   input  logic           RST_N,
   input  logic           EN,
   input  logic [9:0]     CYCLE_LENGTH,
   input  logic [9:0]     STROBE_EDGE,
   input  logic [9:0]     WINDOW_END,
   input  logic           MODE,
   input  logic           DUT_IN,
   input  logic           EXP,
   input  logic           MASK,
   input  logic           CLR_FAIL,
   output logic           CYCLE_DONE,
   output logic           RESULT_FAIL,
   output logic           STICKY_FAIL,
   output logic [FCW-1:0] FAIL_COUNT,
   output logic [FCW-1:0] FIRST_FAIL_IDX,
   output logic [FCW-1:0] CYCLE_IDX
);

   localparam logic [FCW-1:0] ONE  = FCW'(1);
   localparam logic [FCW-1:0] ZERO = '0;

   // Test-cycle counter and per-cycle captured controls
   logic [9:0]     cnt_q, cnt_d;
   logic           en_q, en_d;
   logic           exp_q, exp_d;
   logic           mask_q, mask_d;
   logic           mode_q, mode_d;
   // Per-cycle strobe flags: seen = a strobe point was evaluated, mis = a mismatch
   logic           seen_q, seen_d;
   logic           mis_q, mis_d;
   // Result and statistics
   logic           done_q, done_d;
   logic           result_q, result_d;
   logic           sticky_q, sticky_d;
   logic [FCW-1:0] fcnt_q, fcnt_d;
   logic [FCW-1:0] ffi_q, ffi_d;
   logic [FCW-1:0] idx_q, idx_d;

   // Intermediate combinational terms
   logic [9:0]     len_eff;
   logic [9:0]     win_hi;
   logic           first;
   logic           exp_c, mask_c, mode_c;
   logic           hit;
   logic           seen_now, mis_now;
   logic           last;
   logic           fail;
   logic           rise;
   logic [FCW-1:0] idx_base;
   logic           sticky_base;
   logic [FCW-1:0] fcnt_base;
   logic [FCW-1:0] ffi_base;

   // Strobe evaluation, cycle completion and statistics next-state
   always_comb begin
      len_eff     = (CYCLE_LENGTH == 10'd0) ? 10'd1 : CYCLE_LENGTH;
      win_hi      = (WINDOW_END < STROBE_EDGE) ? STROBE_EDGE : WINDOW_END;
      first       = (cnt_q == 10'd1);
      // At cnt==1 the controls are being captured, so the live inputs apply
      exp_c       = first ? EXP  : exp_q;
      mask_c      = first ? MASK : mask_q;
      mode_c      = first ? MODE : mode_q;
      hit         = mode_c ? ((cnt_q >= STROBE_EDGE) && (cnt_q <= win_hi))
                           : (cnt_q == STROBE_EDGE);
      // Flags restart at cnt==1 and include this clock's strobe
      seen_now    = (!first && seen_q) || hit;
      mis_now     = (!first && mis_q) || (hit && (DUT_IN != exp_c));
      last        = EN && (cnt_q == len_eff);
      fail        = last && !mask_c && (mis_now || !seen_now);
      rise        = EN && !en_q;
      idx_base    = rise ? ZERO : idx_q;
      // A clear in the same clock as a failing completion is applied first
      sticky_base = CLR_FAIL ? 1'b0 : sticky_q;
      fcnt_base   = CLR_FAIL ? ZERO : fcnt_q;
      ffi_base    = CLR_FAIL ? ZERO : ffi_q;

      cnt_d    = cnt_q + 10'd1;
      en_d     = EN;
      exp_d    = exp_c;
      mask_d   = mask_c;
      mode_d   = mode_c;
      seen_d   = seen_now;
      mis_d    = mis_now;
      done_d   = last;
      result_d = result_q;
      sticky_d = sticky_base;
      fcnt_d   = fcnt_base;
      ffi_d    = ffi_base;
      idx_d    = idx_base;

      if (!EN) begin
         // Disabled or aborted: discard the partial cycle
         cnt_d  = 10'd1;
         seen_d = 1'b0;
         mis_d  = 1'b0;
      end else if (last) begin
         cnt_d    = 10'd1;
         result_d = fail;
         idx_d    = idx_base + ONE;
      end

      if (fail) begin
         sticky_d = 1'b1;
         fcnt_d   = (fcnt_base == '1) ? fcnt_base : fcnt_base + ONE;
         ffi_d    = sticky_base ? ffi_base : idx_base;
      end
   end

   // State registers with asynchronous active-low clear
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         cnt_q    <= 10'd1;
         en_q     <= 1'b0;
         exp_q    <= 1'b0;
         mask_q   <= 1'b0;
         mode_q   <= 1'b0;
         seen_q   <= 1'b0;
         mis_q    <= 1'b0;
         done_q   <= 1'b0;
         result_q <= 1'b0;
         sticky_q <= 1'b0;
         fcnt_q   <= '0;
         ffi_q    <= '0;
         idx_q    <= '0;
      end else begin
         cnt_q    <= cnt_d;
         en_q     <= en_d;
         exp_q    <= exp_d;
         mask_q   <= mask_d;
         mode_q   <= mode_d;
         seen_q   <= seen_d;
         mis_q    <= mis_d;
         done_q   <= done_d;
         result_q <= result_d;
         sticky_q <= sticky_d;
         fcnt_q   <= fcnt_d;
         ffi_q    <= ffi_d;
         idx_q    <= idx_d;
      end
   end

   assign CYCLE_DONE     = done_q;
   assign RESULT_FAIL    = result_q;
   assign STICKY_FAIL    = sticky_q;
   assign FAIL_COUNT     = fcnt_q;
   assign FIRST_FAIL_IDX = ffi_q;
   assign CYCLE_IDX      = idx_q;

endmodule

// File: tb/tb_strobe_cmp.sv
// tb_strobe_cmp: directed bench for strobe_cmp with a result scoreboard.
module tb_strobe_cmp;

   localparam int FCW = 4;

   // Clock and DUT signals
   logic           clk = 1'b0;
   logic           rst_n;
   logic           en;
   logic [9:0]     cyc_len;
   logic [9:0]     strobe_edge;
   logic [9:0]     window_end;
   logic           mode;
   logic           dut_in;
   logic           exp_v;
   logic           mask;
   logic           clr_fail;
   logic           done;
   logic           result;
   logic           sticky;
   logic [FCW-1:0] fc;
   logic [FCW-1:0] ffi;
   logic [FCW-1:0] idx;

   // Scoreboard and expected statistics
   logic [FCW:0]   exp_q[$];
   logic [FCW-1:0] m_fc;
   logic [FCW-1:0] m_ffi;
   logic [FCW-1:0] m_idx;
   logic           m_sticky;
   logic           m_result;
   int             checks = 0;
   int             failures = 0;

   always #5 clk = ~clk;

   strobe_cmp #(.FCW(FCW)) dut (
      .CLK            (clk),
      .RST_N          (rst_n),
      .EN             (en),
      .CYCLE_LENGTH   (cyc_len),
      .STROBE_EDGE    (strobe_edge),
      .WINDOW_END     (window_end),
      .MODE           (mode),
      .DUT_IN         (dut_in),
      .EXP            (exp_v),
      .MASK           (mask),
      .CLR_FAIL       (clr_fail),
      .CYCLE_DONE     (done),
      .RESULT_FAIL    (result),
      .STICKY_FAIL    (sticky),
      .FAIL_COUNT     (fc),
      .FIRST_FAIL_IDX (ffi),
      .CYCLE_IDX      (idx)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic check_stats(input string tag);
      chk({tag, "_fail_count"}, 32'(fc), 32'(m_fc));
      chk({tag, "_sticky"}, 32'(sticky), 32'(m_sticky));
      chk({tag, "_first_fail_idx"}, 32'(ffi), 32'(m_ffi));
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_done"}, 32'(done), 32'd0);
      chk({tag, "_result"}, 32'(result), 32'd0);
      chk({tag, "_sticky"}, 32'(sticky), 32'd0);
      chk({tag, "_fail_count"}, 32'(fc), 32'd0);
      chk({tag, "_first_fail_idx"}, 32'(ffi), 32'd0);
      chk({tag, "_cycle_idx"}, 32'(idx), 32'd0);
   endtask

   // Hold EN low for n clocks; no completion may be reported
   task automatic idle(input int n);
      en = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         chk("idle_no_done", 32'(done), 32'd0);
      end
   endtask

   // One test cycle of len clocks: DUT_IN is base_v except gl_v at cnt gl_at.
   // abort_at>0 drops EN at that count; clr_end raises CLR_FAIL on the last
   // clock; flip_exp inverts EXP from cnt 2 on (must not affect the result).
   task automatic run_cycle(input int len, input int gl_at, input logic base_v,
                            input logic gl_v, input logic efail, input int abort_at,
                            input logic clr_end, input logic flip_exp);
      logic rising;
      logic saved_exp;
      rising    = !en;
      saved_exp = exp_v;
      if (rising) m_idx = '0;
      for (int k = 1; k <= len; k++) begin
         if (k == abort_at) begin
            en = 1'b0;
            @(posedge clk);
            #1;
            chk("abort_no_done", 32'(done), 32'd0);
            exp_v = saved_exp;
            return;
         end
         en     = 1'b1;
         dut_in = (k == gl_at) ? gl_v : base_v;
         if (flip_exp && k == 2) exp_v = ~saved_exp;
         if (k == len) begin
            clr_fail = clr_end;
            if (clr_end) begin
               m_fc     = '0;
               m_sticky = 1'b0;
               m_ffi    = '0;
            end
            if (efail) begin
               if (!m_sticky) m_ffi = m_idx;
               m_sticky = 1'b1;
               if (m_fc != '1) m_fc = m_fc + 1'b1;
            end
            m_idx    = m_idx + 1'b1;
            m_result = efail;
            exp_q.push_back({efail, m_idx});
         end
         @(posedge clk);
         #1;
         clr_fail = 1'b0;
         chk("done_timing", 32'(done), 32'(k == len));
         if (k < len) chk("result_hold", 32'(result), 32'(m_result));
         if (rising && k == 1 && len > 1) chk("idx_cleared_on_en", 32'(idx), 32'd0);
      end
      exp_v = saved_exp;
      check_stats("cycle_end");
   endtask

   // Scoreboard: each CYCLE_DONE pulse pops one expected {fail, cycle_idx}
   always @(negedge clk) begin
      if (rst_n && done) begin
         chk("done_expected", 32'(exp_q.size() > 0), 32'd1);
         if (exp_q.size() > 0) chk("result_and_idx", 32'({result, idx}), 32'(exp_q.pop_front()));
      end
   end

   // Watchdog
   initial begin
      #100000;
      failures++;
      $display("FAIL watchdog observed=timeout expected=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      rst_n = 1'b0; en = 1'b0; cyc_len = 10'd10; strobe_edge = 10'd5;
      window_end = 10'd0; mode = 1'b0; dut_in = 1'b0; exp_v = 1'b1;
      mask = 1'b0; clr_fail = 1'b0;
      m_fc = '0; m_ffi = '0; m_idx = '0; m_sticky = 1'b0; m_result = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_all_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Edge strobe at cnt 5, EXP=1
      run_cycle(10, 5, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b1);
      run_cycle(10, 5, 1'b1, 1'b0, 1'b1, 0, 1'b0, 1'b0);
      chk("edge_first_fail_idx", 32'(ffi), 32'd1);
      chk("edge_fail_count", 32'(fc), 32'd1);

      // Window strobe 3..7, EXP=0, one-clock glitches
      idle(1);
      mode = 1'b1; strobe_edge = 10'd3; window_end = 10'd7; exp_v = 1'b0;
      run_cycle(10, 6, 1'b0, 1'b1, 1'b1, 0, 1'b0, 1'b0);
      run_cycle(10, 8, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0);
      run_cycle(10, 3, 1'b0, 1'b1, 1'b1, 0, 1'b0, 1'b0);
      run_cycle(10, 7, 1'b0, 1'b1, 1'b1, 0, 1'b0, 1'b1);
      run_cycle(10, 2, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0);

      // Inverted window collapses to the single point at STROBE_EDGE
      idle(1);
      strobe_edge = 10'd4; window_end = 10'd2;
      run_cycle(10, 5, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0);
      run_cycle(10, 4, 1'b0, 1'b1, 1'b1, 0, 1'b0, 1'b0);

      // Strobe beyond the cycle: unmasked cycles fail, masked ones pass
      idle(1);
      mode = 1'b0; strobe_edge = 10'd12; exp_v = 1'b0;
      run_cycle(10, 0, 1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b0);
      run_cycle(10, 0, 1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b0);
      mask = 1'b1;
      run_cycle(10, 0, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0);
      run_cycle(10, 0, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0);
      mask = 1'b0;

      // CYCLE_LENGTH=0 behaves as 1: a completion every clock, strobe at cnt 1
      idle(1);
      cyc_len = 10'd0; strobe_edge = 10'd1; exp_v = 1'b1;
      run_cycle(1, 1, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0);
      run_cycle(1, 1, 1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b0);
      run_cycle(1, 1, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0);
      exp_v = 1'b0;
      run_cycle(1, 1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);

      // EN dropped at cnt 6 of a mismatching cycle
      idle(1);
      cyc_len = 10'd10; strobe_edge = 10'd3; exp_v = 1'b0;
      run_cycle(10, 0, 1'b1, 1'b1, 1'b1, 6, 1'b0, 1'b0);
      idle(3);
      check_stats("after_abort");
      run_cycle(10, 3, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);

      // Saturation of the 4-bit fail counter, cycle index wraps
      idle(1);
      strobe_edge = 10'd12;
      for (int i = 0; i < 20; i++) run_cycle(10, 0, 1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b0);
      chk("saturated_fail_count", 32'(fc), 32'd15);
      // Clear coincident with a failing completion
      run_cycle(10, 0, 1'b0, 1'b0, 1'b1, 0, 1'b1, 1'b0);
      chk("clr_with_fail_count", 32'(fc), 32'd1);
      chk("clr_with_fail_sticky", 32'(sticky), 32'd1);
      // Clear with a passing (masked) completion
      mask = 1'b1;
      run_cycle(10, 0, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0);
      mask = 1'b0;
      run_cycle(10, 0, 1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b0);

      // Asynchronous reset between clock edges, mid-cycle
      idle(1);
      strobe_edge = 10'd5; exp_v = 1'b1; en = 1'b1; dut_in = 1'b0;
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      #2;
      rst_n = 1'b0;
      #1;
      check_all_zero("async_reset");
      @(negedge clk);
      rst_n = 1'b1;
      m_fc = '0; m_ffi = '0; m_idx = '0; m_sticky = 1'b0; m_result = 1'b0;
      run_cycle(10, 5, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0);
      run_cycle(10, 5, 1'b1, 1'b0, 1'b1, 0, 1'b0, 1'b0);

      idle(2);
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
